amc_sample_monitor: RTL and testbench
=====================================

# amc_sample_monitor

Post-decimation sample conditioner that sits directly downstream of the AMC1303 decimation/CDC stage, consuming its 16-bit sample word and data-enable strobe. It calibrates and removes the zero-current offset and produces saturated signed samples. It also produces block-averaged samples for the motor/battery telemetry path and an optional latched overcurrent fault for the rover's power protection logic. All logic runs in the `mclk` domain; no CDC inside.

## Interface
- `CAL_LOG2`, 4: log2 of the number of samples averaged to compute the offset (1..8).
- `AVG_LOG2`, 3: log2 of the block-average window length (1..8).
- `OC_THRESH`, 16'd24000: unsigned magnitude threshold on the corrected sample.
- `OC_COUNT`, 3: consecutive over-threshold samples required to trip (1..255).
- `mclk`  in  1  system clock; single clock domain.
- `resetn`  in  1  reset; asynchronous assert, active-low.
- `sample_data`  in  16  unsigned offset-binary sample from the decimation stage.
- `sample_en`  in  1  data-enable level from the decimation stage; each rising edge marks one new sample.
- `cal_req`  in  1  one-cycle pulse; restarts offset calibration.
- `oc_clear`  in  1  one-cycle pulse; clears `oc_fault`.
- `corr_data`  out  16  signed, offset-corrected, saturated sample.
- `corr_valid`  out  1  one-cycle pulse qualifying `corr_data`.
- `avg_data`  out  16  signed block average.
- `avg_valid`  out  1  one-cycle pulse qualifying `avg_data`.
- `offset`  out  16  current calibrated offset.
- `cal_done`  out  1  high while in RUN.
- `oc_fault`  out  1  latched overcurrent fault.

## Operation
- Edge detect: register `sample_en`. A sample event occurs in a cycle where `sample_en`=1 and the previous value was 0. In that cycle `sample_data` is captured. A held-high `sample_en` yields exactly one event.
- FSM states:
  - CAL: the reset state. Accumulates raw samples in a (16+CAL_LOG2)-bit unsigned accumulator. On the 2^CAL_LOG2-th sample, `offset` <= accumulator sum >> CAL_LOG2 (truncate), then go to RUN, and clear the accumulator and sample counter.
  - RUN: correction, averaging and OC are active.
  - `cal_req` in either state goes to CAL and clears the cal accumulator, the cal counter, the average accumulator/counter and the OC counter. `offset` keeps its old value until the new calibration completes.
  - `cal_req` coincident with a sample event: the request wins, and the sample is discarded.
- Correction: diff = {1'b0,sample} - {1'b0,offset} as 17-bit signed. Saturate to [-32768, 32767]. Correction runs only in RUN. No `corr_valid` is produced in CAL.
- Averaging: a (16+AVG_LOG2)-bit signed accumulator of corrected samples. On the 2^AVG_LOG2-th sample, `avg_data` = sum >>> AVG_LOG2 (arithmetic shift, floor). The accumulator is then reloaded to 0, giving non-overlapping windows.
- Overcurrent: mag = |corr| computed in 17 bits, so |-32768| = 32768. For each RUN sample:
  - if mag > OC_THRESH, the counter increments, saturating at OC_COUNT; otherwise it clears to 0.
  - `oc_fault` sets when the counter reaches OC_COUNT.
  - `oc_fault` holds until `oc_clear`. A set and a clear in the same cycle leave it set.
  - `oc_clear` does not reset the counter.

## Timing
- Reset values: `corr_data`=0, `corr_valid`=0, `avg_data`=0, `avg_valid`=0, `offset`=16'h8000, `cal_done`=0, `oc_fault`=0, FSM=CAL, all counters/accumulators 0.
- Sample event in cycle N:
  - `corr_data`/`corr_valid` at N+1.
  - `avg_valid` at N+2 for the window-completing sample.
  - `oc_fault` rises at N+2 for the tripping sample.
- Final calibration sample in cycle N: `offset` updates and `cal_done` rises at N+1. The next sample event is corrected with the new offset.
- `cal_req` in cycle N: `cal_done` low at N+1.
- Throughput: one sample per 2 `mclk` cycles minimum (edge detect). `corr_data`/`avg_data` hold their value between pulses.

## Configuration
- `AMC_MONITOR_OC_TRIP_EN`:
  - Defined: the overcurrent counter, comparator and latch are built as described.
  - Undefined: the OC logic is removed, `oc_fault` is tied 0, and `oc_clear` is ignored. Correction, averaging and calibration are unchanged.

## Test plan
- Reset -> all outputs at reset values. Assert `resetn`=0 mid-calibration -> outputs return to reset values immediately, without waiting for a clock edge.
- 16 samples of 0x8010 (CAL_LOG2=4) -> `offset`=0x8010, `cal_done`=1. Next sample 0x9010 -> `corr_data`=0x1000.
- Calibrate with 0x0000, then send 0xFFFF -> `corr_data`=0x7FFF. Calibrate with 0xFFFF, then send 0x0000 -> `corr_data`=0x8000.
- With offset 0x8000, send 8 samples with corrected values -3,-3,-3,-3,-3,-3,-3,-2 (sum -23) -> `avg_data`=-3 (0xFFFD), one `avg_valid` pulse. The next 8 samples give an independent window.
- Over-threshold magnitudes 25000, 25000, 25000 -> `oc_fault` rises 2 cycles after the 3rd sample. The sequence 25000, 25000, 100, 25000 -> no fault. `oc_clear` in the same cycle as a trip -> `oc_fault` stays 1.
- `sample_en` held high for 10 cycles -> exactly one `corr_valid`. `cal_req` mid-average -> `cal_done`=0, no `avg_valid` until recalibration completes plus 8 new samples.

Source files
------------

// File: rtl/amc_sample_monitor.sv
// Offset-calibrating sample conditioner: corrected/saturated samples, block averages and,
// when AMC_MONITOR_OC_TRIP_EN is defined, a latched overcurrent fault.
module amc_sample_monitor #(
   parameter int          CAL_LOG2  = 4,
   parameter int          AVG_LOG2  = 3,
   parameter logic [15:0] OC_THRESH = 16'd24000,
   parameter int          OC_COUNT  = 3
) (
   input  logic        mclk,
   input  logic        resetn,
   input  logic [15:0] sample_data,
   input  logic        sample_en,
   input  logic        cal_req,
   input  logic        oc_clear,
   output logic [15:0] corr_data,
   output logic        corr_valid,
   output logic [15:0] avg_data,
   output logic        avg_valid,
   output logic [15:0] offset,
   output logic        cal_done,
   output logic        oc_fault
);

   localparam int CAW = 16 + CAL_LOG2;
   localparam int AAW = 16 + AVG_LOG2;

   typedef enum logic {ST_CAL, ST_RUN} state_t;

   state_t                r_state, w_state_next;
   logic                  r_en_d;
   logic                  w_evt;
   logic [CAW-1:0]        r_cal_acc;
   logic [CAL_LOG2-1:0]   r_cal_cnt;
   logic [CAW-1:0]        w_cal_sum;
   logic                  w_cal_last;
   logic [15:0]           r_offset;
   logic signed [16:0]    w_diff;
   logic [15:0]           w_sat;
   logic [15:0]           r_corr_data;
   logic                  r_corr_valid;
   logic                  w_s2;
   logic signed [AAW-1:0] r_avg_acc;
   logic [AVG_LOG2-1:0]   r_avg_cnt;
   logic signed [AAW-1:0] w_avg_sum;
   logic                  w_avg_last;
   logic [15:0]           r_avg_data;
   logic                  r_avg_valid;

   always_ff @(posedge mclk or negedge resetn) begin
      if (!resetn) r_en_d <= 1'b0;
      else         r_en_d <= sample_en;
   end

   assign w_evt = sample_en & ~r_en_d;

   // FSM: state register / next state / outputs
   always_ff @(posedge mclk or negedge resetn) begin
      if (!resetn) r_state <= ST_CAL;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (cal_req)
         w_state_next = ST_CAL;
      else if (r_state == ST_CAL && w_evt && w_cal_last)
         w_state_next = ST_RUN;
   end

   always_comb begin
      cal_done = (r_state == ST_RUN);
   end

   assign w_cal_last = (r_cal_cnt == {CAL_LOG2{1'b1}});
   assign w_cal_sum  = r_cal_acc + CAW'(sample_data);

   always_ff @(posedge mclk or negedge resetn) begin
      if (!resetn) begin
         r_cal_acc <= '0;
         r_cal_cnt <= '0;
         r_offset  <= 16'h8000;
      end else if (cal_req) begin
         r_cal_acc <= '0;
         r_cal_cnt <= '0;
      end else if (r_state == ST_CAL && w_evt) begin
         if (w_cal_last) begin
            r_offset  <= 16'(w_cal_sum >> CAL_LOG2);
            r_cal_acc <= '0;
            r_cal_cnt <= '0;
         end else begin
            r_cal_acc <= w_cal_sum;
            r_cal_cnt <= r_cal_cnt + CAL_LOG2'(1);
         end
      end
   end

   // 17-bit difference overflows 16 bits exactly when its top two bits disagree
   assign w_diff = $signed({1'b0, sample_data}) - $signed({1'b0, r_offset});
   assign w_sat  = (w_diff[16] != w_diff[15]) ? (w_diff[16] ? 16'h8000 : 16'h7FFF)
                                              : w_diff[15:0];

   always_ff @(posedge mclk or negedge resetn) begin
      if (!resetn) begin
         r_corr_data  <= '0;
         r_corr_valid <= 1'b0;
      end else begin
         r_corr_valid <= 1'b0;
         if (r_state == ST_RUN && w_evt && !cal_req) begin
            r_corr_data  <= w_sat;
            r_corr_valid <= 1'b1;
         end
      end
   end

   // Second stage consumes the registered corrected sample unless a recalibration intervenes
   assign w_s2       = r_corr_valid & ~cal_req;
   assign w_avg_sum  = r_avg_acc + {{AVG_LOG2{r_corr_data[15]}}, r_corr_data};
   assign w_avg_last = (r_avg_cnt == {AVG_LOG2{1'b1}});

   always_ff @(posedge mclk or negedge resetn) begin
      if (!resetn) begin
         r_avg_acc   <= '0;
         r_avg_cnt   <= '0;
         r_avg_data  <= '0;
         r_avg_valid <= 1'b0;
      end else begin
         r_avg_valid <= 1'b0;
         if (cal_req) begin
            r_avg_acc <= '0;
            r_avg_cnt <= '0;
         end else if (w_s2) begin
            if (w_avg_last) begin
               r_avg_data  <= 16'(w_avg_sum >>> AVG_LOG2);
               r_avg_valid <= 1'b1;
               r_avg_acc   <= '0;
               r_avg_cnt   <= '0;
            end else begin
               r_avg_acc <= w_avg_sum;
               r_avg_cnt <= r_avg_cnt + AVG_LOG2'(1);
            end
         end
      end
   end

`ifdef AMC_MONITOR_OC_TRIP_EN
   localparam logic [7:0] OC_CNT_MAX = 8'(OC_COUNT);

   logic [16:0] w_mag;
   logic        w_over;
   logic [7:0]  r_oc_cnt, w_oc_cnt_next;
   logic        r_oc_fault;

   assign w_mag  = r_corr_data[15] ? (17'd0 - {1'b1, r_corr_data}) : {1'b0, r_corr_data};
   assign w_over = (w_mag > {1'b0, OC_THRESH});
   assign w_oc_cnt_next = !w_over ? 8'd0 :
                          (r_oc_cnt == OC_CNT_MAX) ? r_oc_cnt : r_oc_cnt + 8'd1;

   always_ff @(posedge mclk or negedge resetn) begin
      if (!resetn) begin
         r_oc_cnt   <= '0;
         r_oc_fault <= 1'b0;
      end else begin
         if (cal_req)   r_oc_cnt <= '0;
         else if (w_s2) r_oc_cnt <= w_oc_cnt_next;
         // a trip outranks a simultaneous clear
         if (w_s2 && w_oc_cnt_next == OC_CNT_MAX) r_oc_fault <= 1'b1;
         else if (oc_clear)                       r_oc_fault <= 1'b0;
      end
   end

   assign oc_fault = r_oc_fault;
`else
   logic w_unused_oc;
   assign w_unused_oc = oc_clear ^ (|OC_THRESH) ^ (OC_COUNT != 0);
   assign oc_fault    = 1'b0;
`endif

   assign corr_data  = r_corr_data;
   assign corr_valid = r_corr_valid;
   assign avg_data   = r_avg_data;
   assign avg_valid  = r_avg_valid;
   assign offset     = r_offset;

endmodule

// File: tb/tb_amc_sample_monitor.sv
// Directed-vector bench for amc_sample_monitor with hand-computed expectations.
module tb_amc_sample_monitor;

   logic        mclk = 1'b0;
   logic        resetn;
   logic [15:0] sample_data;
   logic        sample_en;
   logic        cal_req;
   logic        oc_clear;
   logic [15:0] corr_data;
   logic        corr_valid;
   logic [15:0] avg_data;
   logic        avg_valid;
   logic [15:0] offset;
   logic        cal_done;
   logic        oc_fault;

   int n_vec = 0;
   int n_err = 0;
   int corr_pulses = 0;
   int avg_pulses  = 0;
   logic [15:0] avg_last = '0;
   int snap_c, snap_a;

   always #5 mclk = ~mclk;

   amc_sample_monitor dut (
      .mclk        (mclk),
      .resetn      (resetn),
      .sample_data (sample_data),
      .sample_en   (sample_en),
      .cal_req     (cal_req),
      .oc_clear    (oc_clear),
      .corr_data   (corr_data),
      .corr_valid  (corr_valid),
      .avg_data    (avg_data),
      .avg_valid   (avg_valid),
      .offset      (offset),
      .cal_done    (cal_done),
      .oc_fault    (oc_fault)
   );

   always @(negedge mclk) begin
      if (corr_valid) corr_pulses++;
      if (avg_valid) begin
         avg_pulses++;
         avg_last = avg_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge mclk);
   endtask

   // one sample event; returns at the negedge of cycle N+1 (corr outputs valid)
   task automatic send(input logic [15:0] v);
      @(negedge mclk);
      sample_data = v;
      sample_en   = 1'b1;
      @(negedge mclk);
      sample_en   = 1'b0;
   endtask

   task automatic send_n(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) send(v);
   endtask

   task automatic pulse_cal;
      @(negedge mclk);
      cal_req = 1'b1;
      @(negedge mclk);
      cal_req = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; sample_data = '0; sample_en = 1'b0; cal_req = 1'b0; oc_clear = 1'b0;
      idle(3);
      check("rst_corr_data", corr_data, 0);
      check("rst_corr_valid", corr_valid, 0);
      check("rst_avg_data", avg_data, 0);
      check("rst_avg_valid", avg_valid, 0);
      check("rst_offset", offset, 16'h8000);
      check("rst_cal_done", cal_done, 0);
      check("rst_oc_fault", oc_fault, 0);
      resetn = 1'b1;

      // partial calibration interrupted by reset must leave no residue
      send_n(16'h1234, 5);
      #2 resetn = 1'b0;
      #1 check("midcal_rst_offset", offset, 16'h8000);
      idle(1);
      resetn = 1'b1;

      send_n(16'h8010, 15);
      check("cal_done_pre", cal_done, 0);
      send(16'h8010);
      check("cal_offset", offset, 16'h8010);
      check("cal_done", cal_done, 1);
      idle(2);
      check("no_corr_in_cal", corr_pulses, 0);
      send(16'h9010);
      check("corr_9010_valid", corr_valid, 1);
      check("corr_9010", corr_data, 16'h1000);
      idle(1);
      check("corr_pulse_width", corr_valid, 0);

      // held-high enable yields one event
      idle(2);
      snap_c = corr_pulses;
      @(negedge mclk);
      sample_data = 16'h8020;
      sample_en   = 1'b1;
      idle(10);
      sample_en = 1'b0;
      idle(3);
      check("held_en_pulses", corr_pulses - snap_c, 1);
      check("held_en_corr", corr_data, 16'h0010);

      // saturation both ways
      pulse_cal;
      check("calreq_cal_done", cal_done, 0);
      send_n(16'h0000, 16);
      check("cal_zero_offset", offset, 16'h0000);
      send(16'hFFFF);
      check("sat_pos", corr_data, 16'h7FFF);
      pulse_cal;
      send_n(16'hFFFF, 16);
      check("cal_ffff_offset", offset, 16'hFFFF);
      send(16'h0000);
      check("sat_neg", corr_data, 16'h8000);

      // averaging with offset 0x8000
      pulse_cal;
      send_n(16'h8000, 16);
      check("cal_8000_offset", offset, 16'h8000);
      idle(2);
      snap_a = avg_pulses;
      send_n(16'h7FFD, 7);
      send(16'h7FFE);
      idle(3);
      check("avg1_pulses", avg_pulses - snap_a, 1);
      check("avg1_data", avg_last, 16'hFFFD);
      check("avg1_hold", avg_data, 16'hFFFD);
      send_n(16'h8010, 8);
      idle(3);
      check("avg2_pulses", avg_pulses - snap_a, 2);
      check("avg2_data", avg_last, 16'h0010);
      send_n(16'h8005, 4);
      send_n(16'h7FFA, 4);
      idle(3);
      check("avg3_floor", avg_last, 16'hFFFF);

      // recalibration mid-window restarts the average window
      snap_a = avg_pulses;
      send_n(16'h8008, 3);
      pulse_cal;
      check("midavg_cal_done", cal_done, 0);
      send_n(16'h8000, 16);
      send_n(16'h8008, 7);
      idle(3);
      check("midavg_no_avg", avg_pulses - snap_a, 0);
      send(16'h8008);
      idle(3);
      check("midavg_avg_pulse", avg_pulses - snap_a, 1);
      check("midavg_avg_data", avg_last, 16'h0008);

`ifdef AMC_MONITOR_OC_TRIP_EN
      send(16'hE1A8); send(16'hE1A8); send(16'h8064); send(16'hE1A8);
      idle(2);
      check("oc_broken_run", oc_fault, 0);
      send(16'h8064);
      send_n(16'hDDC0, 3);            // magnitude 24000 equals threshold
      idle(2);
      check("oc_at_thresh", oc_fault, 0);
      send(16'hE1A8);
      send(16'h1E58);
      check("oc_neg_corr", corr_data, 16'h9E58);
      send(16'hE1A8);
      check("oc_trip_n1", oc_fault, 0);
      idle(1);
      check("oc_trip_n2", oc_fault, 1);
      idle(3);
      check("oc_latched", oc_fault, 1);
      @(negedge mclk) oc_clear = 1'b1;
      @(negedge mclk) oc_clear = 1'b0;
      check("oc_cleared", oc_fault, 0);
      send(16'h8064);
      send_n(16'hE1A8, 2);
      idle(2);
      check("oc_two_only", oc_fault, 0);
      @(negedge mclk);
      sample_data = 16'hE1A8;
      sample_en   = 1'b1;
      @(negedge mclk);
      sample_en = 1'b0;
      oc_clear  = 1'b1;
      @(negedge mclk);
      oc_clear = 1'b0;
      check("oc_set_beats_clear", oc_fault, 1);
`else
      send_n(16'hE1A8, 4);
      @(negedge mclk) oc_clear = 1'b1;
      @(negedge mclk) oc_clear = 1'b0;
      idle(2);
      check("oc_disabled", oc_fault, 0);
`endif

      // asynchronous reset from RUN with non-reset outputs
      send(16'h8123);
      check("pre_rst_cal_done", cal_done, 1);
      #2 resetn = 1'b0;
      #1;
      check("async_cal_done", cal_done, 0);
      check("async_offset", offset, 16'h8000);
      check("async_corr", corr_data, 0);
      check("async_avg", avg_data, 0);
      check("async_oc", oc_fault, 0);
      idle(2);
      resetn = 1'b1;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
